cross_bar_slave_mem: RTL and testbench



---
 rtl/cross_bar_slave_mem_if.sv | 14 +
 rtl/cross_bar_slave_mem.sv | 72 +++++++
 tb/tb_cross_bar_slave_mem.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cross_bar_slave_mem_if.sv
// cross_bar_slave_mem_if: req/ack bus between a cross bar slave port and its memory endpoint
interface cross_bar_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  s_req;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_cmd;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_ack;
    logic [DATA_WIDTH-1:0] s_rdata;
    modport master (output s_req, s_addr, s_cmd, s_wdata, input s_ack, s_rdata);
    modport slave (input s_req, s_addr, s_cmd, s_wdata, output s_ack, s_rdata);
endinterface

// File: rtl/cross_bar_slave_mem.sv
// cross_bar_slave_mem: word-addressed memory slave with fixed wait states and a saturating transaction counter
module cross_bar_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    cross_bar_slave_mem_if.slave        bus,
    output logic                        busy,
    output logic [15:0]                 txn_count
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [3:0]            cnt;
    logic [IW-1:0]         idx;
    logic                  cmd;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = (state == S_IDLE) ? (bus.s_req ? (WAIT_CYCLES == 0 ? S_ACK : S_WAIT) : S_IDLE) :
                    (state == S_WAIT) ? (cnt == 4'd1 ? S_ACK : S_WAIT) : S_IDLE;
    end

    // Outputs are flops loaded from the next state so nothing combinational reaches the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            cmd         <= 1'b0;
            wdata       <= '0;
            bus.s_ack   <= 1'b0;
            bus.s_rdata <= '0;
            busy        <= 1'b0;
            txn_count   <= '0;
        end else begin
            state     <= state_nxt;
            bus.s_ack <= state_nxt == S_ACK;
            busy      <= state_nxt != S_IDLE;
            if (state == S_IDLE && bus.s_req) begin
                idx   <= bus.s_addr[2 +: IW];
                cmd   <= bus.s_cmd;
                wdata <= bus.s_wdata;
                cnt   <= 4'(WAIT_CYCLES);
            end
            if (state == S_WAIT)
                cnt <= cnt - 4'd1;
            if (state == S_ACK) begin
                if (!cmd)
                    bus.s_rdata <= mem[idx];
                if (txn_count != 16'hFFFF)
                    txn_count <= txn_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state == S_ACK && cmd) begin
            mem[idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// tb_cross_bar_slave_mem: randomized and directed checks of two endpoints (0 and 3 wait states) against an array model
module tb_cross_bar_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req3 = 1'b0, cmd = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy0, busy3;
    logic [15:0] cnt0, cnt3;
    bit          sel = 1'b0;
    int          checks = 0, errors = 0;
    logic [31:0] mm [2][256];
    logic [31:0] rd_m [2];
    int          cn_m [2];

    cross_bar_slave_mem_if if0 ();
    cross_bar_slave_mem_if if3 ();
    assign if0.s_req = req0;
    assign if0.s_addr = addr;
    assign if0.s_cmd = cmd;
    assign if0.s_wdata = wdata;
    assign if3.s_req = req3;
    assign if3.s_addr = addr;
    assign if3.s_cmd = cmd;
    assign if3.s_wdata = wdata;

    cross_bar_slave_mem #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(if0), .busy(busy0), .txn_count(cnt0));
    cross_bar_slave_mem #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(if3), .busy(busy3), .txn_count(cnt3));

    logic        ack_o, busy_o;
    logic [31:0] rd_o;
    logic [15:0] cnt_o;
    assign ack_o  = sel ? if3.s_ack : if0.s_ack;
    assign busy_o = sel ? busy3 : busy0;
    assign rd_o   = sel ? if3.s_rdata : if0.s_rdata;
    assign cnt_o  = sel ? cnt3 : cnt0;

    always #5 clk = ~clk;

    task automatic clear_model;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) mm[s][i] = '0;
            rd_m[s] = '0;
            cn_m[s] = 0;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req3 = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge of the first idle cycle after ack
    task automatic txn(input bit c, input logic [31:0] a, input logic [31:0] d, input bit keep);
        int w, idx;
        w = sel ? 3 : 0;
        idx = int'((a >> 2) % 256);
        cmd = c; addr = a; wdata = d;
        if (sel) req3 = 1'b1; else req0 = 1'b1;
        for (int k = 1; k <= w + 1; k++) begin
            @(negedge clk);
            checks++;
            if (ack_o !== 1'(k == w + 1)) begin
                errors++;
                $display("FAIL ack_timing dut%0d cycle %0d: got %b want %b", sel, k, ack_o, k == w + 1);
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_high dut%0d cycle %0d: got %b want 1", sel, k, busy_o);
            end
        end
        if (c) mm[sel][idx] = d; else rd_m[sel] = mm[sel][idx];
        if (cn_m[sel] < 65535) cn_m[sel]++;
        if (!keep) begin req0 = 1'b0; req3 = 1'b0; end
        @(negedge clk);
        checks++;
        if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL after_ack dut%0d: ack=%b busy=%b want 0 0", sel, ack_o, busy_o);
        end
        checks++;
        if (rd_o !== rd_m[sel]) begin
            errors++;
            $display("FAIL rdata dut%0d addr %h: got %h want %h", sel, a, rd_o, rd_m[sel]);
        end
        checks++;
        if (cnt_o !== 16'(cn_m[sel])) begin
            errors++;
            $display("FAIL txn_count dut%0d: got %0d want %0d", sel, cnt_o, cn_m[sel]);
        end
    endtask

    task automatic test_reset;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (ack_o !== 1'b0 || busy_o !== 1'b0 || rd_o !== '0 || cnt_o !== '0) begin
                errors++;
                $display("FAIL reset_values dut%0d: ack=%b busy=%b rdata=%h count=%0d want all 0", s, ack_o, busy_o, rd_o, cnt_o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        sel = 1'b0;
        do_reset();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0);
        checks++;
        if (rd_o !== 32'hDEADBEEF || cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL basic_rw: rdata=%h count=%0d want deadbeef 2", rd_o, cnt_o);
        end
    endtask

    task automatic test_wait;
        sel = 1'b1;
        do_reset();
        txn(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_alias;
        sel = 1'b0;
        do_reset();
        txn(1'b1, 32'h000, 32'h1, 1'b0);
        txn(1'b1, 32'h400, 32'h2, 1'b0);
        txn(1'b0, 32'h000, 32'h0, 1'b0);
        checks++;
        if (rd_o !== 32'h2) begin
            errors++;
            $display("FAIL alias_400: got %h want 2", rd_o);
        end
        txn(1'b1, 32'h004, 32'h7, 1'b0);
        txn(1'b0, 32'h003, 32'h0, 1'b0);
        checks++;
        if (rd_o !== 32'h2) begin
            errors++;
            $display("FAIL alias_low_bits: got %h want 2", rd_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            txn(1'b1, 32'h20, d, 1'b1);
            txn(1'b0, 32'h20, 32'h0, i != 7);
            checks++;
            if (rd_o !== d) begin
                errors++;
                $display("FAIL b2b_raw %0d: got %h want %h", i, rd_o, d);
            end
        end
    endtask

    task automatic test_reset_mid;
        sel = 1'b1;
        do_reset();
        txn(1'b1, 32'h8, 32'h11111111, 1'b0);
        cmd = 1'b1; addr = 32'h8; wdata = 32'hA5A5A5A5; req3 = 1'b1;
        @(negedge clk);
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy3);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy3 !== 1'b0 || if3.s_ack !== 1'b0 || cnt3 !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b ack=%b count=%0d want 0 0 0", busy3, if3.s_ack, cnt3);
        end
        req3 = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if3.s_ack !== 1'b0 || busy3 !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_ack cycle %0d: ack=%b busy=%b want 0 0", i, if3.s_ack, busy3);
            end
        end
        txn(1'b0, 32'h8, 32'h0, 1'b0);
        checks++;
        if (rd_o !== 32'h0 || cnt3 !== 16'd1) begin
            errors++;
            $display("FAIL mid_read_after: rdata=%h count=%0d want 0 1", rd_o, cnt3);
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 100; i++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 10) | $urandom_range(0, 3);
                txn(1'($urandom), a, $urandom, i != 99 && 1'($urandom));
            end
        end
    endtask

    task automatic test_saturate;
        sel = 1'b0;
        @(negedge clk);
        u0.txn_count = 16'hFFFE;
        cn_m[0] = 65534;
        for (int i = 0; i < 3; i++) txn(1'($urandom), $urandom, $urandom, 1'b0);
        checks++;
        if (cnt0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: got %h want ffff", cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
